// File: rtl/wrap_scheduler.sv
// Round-robin wrap scheduler feeding the fetch stage: tracks per-wrap active and
// in-flight state and issues one registered one-hot grant per cycle.
module wrap_scheduler #(
    parameter int NUM_WRAPS = 4,
    parameter int WRAP_ID_WIDTH = $clog2(NUM_WRAPS),
    parameter logic [NUM_WRAPS-1:0] RESET_ACTIVE_MASK = 'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     launchValid,
    input  logic [WRAP_ID_WIDTH-1:0] launchWrapId,
    input  logic                     haltValid,
    input  logic [WRAP_ID_WIDTH-1:0] haltWrapId,
    input  logic [NUM_WRAPS-1:0]     stallMask,
    input  logic                     fetchReady,
    input  logic                     fetchDoneValid,
    input  logic [WRAP_ID_WIDTH-1:0] fetchDoneWrapId,
    output logic [NUM_WRAPS-1:0]     selectedWrapOH,
    output logic [WRAP_ID_WIDTH-1:0] selectedWrapId,
    output logic                     selectedValid,
    output logic [NUM_WRAPS-1:0]     activeMask,
    output logic [NUM_WRAPS-1:0]     inFlightMask
);

    localparam logic [WRAP_ID_WIDTH-1:0] RR_RESET = WRAP_ID_WIDTH'(NUM_WRAPS - 1);

    function automatic logic [NUM_WRAPS-1:0] toOneHot(input logic [WRAP_ID_WIDTH-1:0] id);
        logic [NUM_WRAPS-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    logic [WRAP_ID_WIDTH-1:0] rrPtr;
    logic [NUM_WRAPS-1:0]     eligible;
    logic [WRAP_ID_WIDTH-1:0] candidate;
    logic [WRAP_ID_WIDTH-1:0] grantId;
    logic                     grantFound;
    logic                     issue;
    logic [NUM_WRAPS-1:0]     launchOH;
    logic [NUM_WRAPS-1:0]     haltOH;
    logic [NUM_WRAPS-1:0]     doneOH;
    logic [NUM_WRAPS-1:0]     grantOH;
    logic [NUM_WRAPS-1:0]     activeNext;
    logic [NUM_WRAPS-1:0]     inFlightNext;

    // Eligibility: registered state plus the live stall mask
    assign eligible = activeMask & ~inFlightMask & ~stallMask;

    // Search starts one past the last grant; index arithmetic wraps naturally
    // because NUM_WRAPS is a power of two.
    always_comb begin
        grantFound = 1'b0;
        grantId    = '0;
        candidate  = '0;
        for (int i = 1; i <= NUM_WRAPS; i++) begin
            candidate = rrPtr + WRAP_ID_WIDTH'(i);
            if (!grantFound && eligible[candidate]) begin
                grantFound = 1'b1;
                grantId    = candidate;
            end
        end
    end

    assign issue    = fetchReady && grantFound;
    assign launchOH = launchValid    ? toOneHot(launchWrapId)    : '0;
    assign haltOH   = haltValid      ? toOneHot(haltWrapId)      : '0;
    assign doneOH   = fetchDoneValid ? toOneHot(fetchDoneWrapId) : '0;
    assign grantOH  = issue          ? toOneHot(grantId)         : '0;

    // Halt is applied after launch so it wins on a same-wrap collision
    assign activeNext   = (activeMask | launchOH) & ~haltOH;
    assign inFlightNext = (inFlightMask & ~doneOH) | grantOH;

    // Registered grant stage
    always_ff @(posedge clk) begin
        if (reset) begin
            activeMask     <= RESET_ACTIVE_MASK;
            inFlightMask   <= '0;
            selectedWrapOH <= '0;
            selectedWrapId <= '0;
            selectedValid  <= 1'b0;
            rrPtr          <= RR_RESET;
        end else begin
            activeMask     <= activeNext;
            inFlightMask   <= inFlightNext;
            selectedWrapOH <= grantOH;
            selectedWrapId <= issue ? grantId : '0;
            selectedValid  <= issue;
            if (issue) begin
                rrPtr <= grantId;
            end
        end
    end

endmodule

// File: tb/tb_wrap_scheduler.sv
// Directed, table-driven bench for wrap_scheduler with NUM_WRAPS = 4.
module tb_wrap_scheduler;

    logic       clk;
    logic       reset;
    logic       launchValid;
    logic [1:0] launchWrapId;
    logic       haltValid;
    logic [1:0] haltWrapId;
    logic [3:0] stallMask;
    logic       fetchReady;
    logic       fetchDoneValid;
    logic [1:0] fetchDoneWrapId;
    logic [3:0] selectedWrapOH;
    logic [1:0] selectedWrapId;
    logic       selectedValid;
    logic [3:0] activeMask;
    logic [3:0] inFlightMask;

    int passed = 0;
    int total  = 0;

    wrap_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .launchValid     (launchValid),
        .launchWrapId    (launchWrapId),
        .haltValid       (haltValid),
        .haltWrapId      (haltWrapId),
        .stallMask       (stallMask),
        .fetchReady      (fetchReady),
        .fetchDoneValid  (fetchDoneValid),
        .fetchDoneWrapId (fetchDoneWrapId),
        .selectedWrapOH  (selectedWrapOH),
        .selectedWrapId  (selectedWrapId),
        .selectedValid   (selectedValid),
        .activeMask      (activeMask),
        .inFlightMask    (inFlightMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [1:0] lid;
        logic       hv;
        logic [1:0] hid;
        logic [3:0] stall;
        logic       rdy;
        logic       dv;
        logic [1:0] did;
        logic [3:0] expOH;
        logic [3:0] expA;
        logic [3:0] expF;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic lv, input logic [1:0] lid,
                                input logic hv, input logic [1:0] hid, input logic [3:0] stall,
                                input logic rdy, input logic dv, input logic [1:0] did,
                                input logic [3:0] expOH, input logic [3:0] expA,
                                input logic [3:0] expF);
        vec_t v;
        v.rst = rst; v.lv = lv; v.lid = lid; v.hv = hv; v.hid = hid; v.stall = stall;
        v.rdy = rdy; v.dv = dv; v.did = did; v.expOH = expOH; v.expA = expA; v.expF = expF;
        return v;
    endfunction

    function automatic logic [1:0] encode(input logic [3:0] oh);
        logic [1:0] id;
        id = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) id = 2'(k);
        end
        return id;
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input vec_t v);
        reset           = v.rst;
        launchValid     = v.lv;
        launchWrapId    = v.lid;
        haltValid       = v.hv;
        haltWrapId      = v.hid;
        stallMask       = v.stall;
        fetchReady      = v.rdy;
        fetchDoneValid  = v.dv;
        fetchDoneWrapId = v.did;
    endtask

    task automatic checkAll(input int idx, input logic [3:0] eOH, input logic [3:0] eA,
                            input logic [3:0] eF);
        check("selectedWrapOH", idx, selectedWrapOH, eOH);
        check("selectedWrapId", idx, {2'b00, selectedWrapId}, {2'b00, encode(eOH)});
        check("selectedValid", idx, {3'b000, selectedValid}, {3'b000, |eOH});
        check("activeMask", idx, activeMask, eA);
        check("inFlightMask", idx, inFlightMask, eF);
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; launchValid = 1'b0; launchWrapId = '0; haltValid = 1'b0;
        haltWrapId = '0; stallMask = '0; fetchReady = 1'b0; fetchDoneValid = 1'b0;
        fetchDoneWrapId = '0;

        //             rst lv lid hv hid stall    rdy dv did  expOH    expA     expF
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0001, 4'b0000));
        // wrap 0 alone, done two cycles after each grant
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0001, 4'b0001, 4'b0001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 4'b0001, 4'b0001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0001, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0001, 4'b0001, 4'b0001));
        // launch 1,2,3 and round-robin with immediate completions
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0011, 4'b0000));
        vecs.push_back(mk(0, 1, 2, 0, 0, 4'b0000, 1, 0, 0, 4'b0010, 4'b0111, 4'b0010));
        vecs.push_back(mk(0, 1, 3, 0, 0, 4'b0000, 1, 1, 1, 4'b0100, 4'b1111, 4'b0100));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 2, 4'b1000, 4'b1111, 4'b1000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 3, 4'b0001, 4'b1111, 4'b0001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 4'b0010, 4'b1111, 4'b0010));
        // fetchReady low for three cycles holds the pointer at 1
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 4'b0000, 4'b1111, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0100, 4'b1111, 4'b0100));
        // wrap 1 stalled, then released
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 1, 1, 2, 4'b1000, 4'b1111, 4'b1000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 1, 1, 3, 4'b0001, 4'b1111, 4'b0001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 1, 1, 0, 4'b0100, 4'b1111, 4'b0100));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 1, 1, 2, 4'b1000, 4'b1111, 4'b1000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 3, 4'b0001, 4'b1111, 4'b0001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 4'b0010, 4'b1111, 4'b0010));
        // launch+halt of wrap 2 together, then halt in-flight wrap 3
        vecs.push_back(mk(0, 1, 2, 1, 2, 4'b0000, 1, 1, 1, 4'b0100, 4'b1011, 4'b0100));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 2, 4'b1000, 4'b1011, 4'b1000));
        vecs.push_back(mk(0, 0, 0, 1, 3, 4'b0000, 1, 0, 0, 4'b0001, 4'b0011, 4'b1001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 4'b0010, 4'b0011, 4'b1010));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 4'b0001, 4'b0011, 4'b1001));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 3, 4'b0010, 4'b0011, 4'b0011));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0011, 4'b0010));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 1, 4'b0001, 4'b0011, 4'b0001));
        // stray done ignored; launch and halt of different wraps both apply
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 0, 1, 2, 4'b0000, 4'b0011, 4'b0001));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0010, 4'b0001));
        // bring three wraps in flight ahead of the mid-traffic reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 0, 1, 0, 4'b0000, 4'b0011, 4'b0000));
        vecs.push_back(mk(0, 1, 2, 0, 0, 4'b0000, 1, 0, 0, 4'b0010, 4'b0111, 4'b0010));
        vecs.push_back(mk(0, 1, 3, 0, 0, 4'b0000, 1, 0, 0, 4'b0100, 4'b1111, 4'b0110));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b1000, 4'b1111, 4'b1110));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            checkAll(i, vecs[i].expOH, vecs[i].expA, vecs[i].expF);
        end

        // Reset with traffic and competing requests on the same edge
        @(negedge clk);
        v = mk(1, 1, 1, 1, 2, 4'b0000, 1, 1, 1, 4'b0000, 4'b0001, 4'b0000);
        drive(v);
        @(posedge clk);
        #1;
        checkAll(100, v.expOH, v.expA, v.expF);

        @(negedge clk);
        v = mk(0, 0, 0, 0, 0, 4'b0000, 1, 0, 0, 4'b0001, 4'b0001, 4'b0001);
        drive(v);
        @(posedge clk);
        #1;
        checkAll(101, v.expOH, v.expA, v.expF);

        @(negedge clk);
        v = mk(0, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0001, 4'b0000);
        drive(v);
        @(posedge clk);
        #1;
        checkAll(102, v.expOH, v.expA, v.expF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
